// File: rtl/cell_window_builder_pkg.sv
//------------------------------------------------------------------------------
// cell_window_builder_pkg
// Shared cell-processing types, window geometry and FSM encoding for the
// cell window builder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cell_window_builder_pkg;

   typedef logic [7:0] pixel_t;
   typedef logic [7:0] userInput_t;

   localparam int opCodeWidth = 4;
   localparam int cellDepth   = 9 * $bits(pixel_t);

   // Window slot indices: k = 3*wrow + wcol, k=0 oldest/top-left
   localparam int K_TL  = 0;
   localparam int K_CTR = 4;
   localparam int K_BR  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } cellWinState_t;

endpackage

`default_nettype wire

// File: rtl/cell_window_builder_if.sv
//------------------------------------------------------------------------------
// cell_window_builder_if
// Cell output bundle. The master modport is the imagePorts side that
// produces cells; the slave modport is the consuming cell processor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cell_window_builder_if
   import cell_window_builder_pkg::*;
#(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64,
   parameter int PIXEL_W    = 8,
   parameter int OPCODE_W   = opCodeWidth,
   parameter int USER_W     = 8
) ();

   logic                          cell_valid;
   logic                          cell_ready;
   logic [9*PIXEL_W-1:0]          cellA;
   logic [9*PIXEL_W-1:0]          cellB;
   logic [USER_W-1:0]             userInputA;
   logic [OPCODE_W-1:0]           opcode;
   logic [$clog2(IMG_HEIGHT)-1:0] cell_row;
   logic [$clog2(IMG_WIDTH)-1:0]  cell_col;

   modport master (
      output cell_valid, cellA, cellB, userInputA, opcode, cell_row, cell_col,
      input  cell_ready
   );

   modport slave (
      input  cell_valid, cellA, cellB, userInputA, opcode, cell_row, cell_col,
      output cell_ready
   );

endinterface

`default_nettype wire

// File: rtl/cell_window_builder_line_buffer.sv
//------------------------------------------------------------------------------
// cell_window_builder_line_buffer
// Two-row pixel line store for one image. Row 1 holds the older row.
// Reads are combinational at the current column; a write pushes the pixel
// into row 0 and moves the previous row-0 entry into row 1.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cell_window_builder_line_buffer #(
   parameter int IMG_WIDTH = 64,
   parameter int PIXEL_W   = 8,
   parameter int CW        = $clog2(IMG_WIDTH)
) (
   input  wire logic               clk,
   input  wire logic               wr_en,
   input  wire logic [CW-1:0]      col,
   input  wire logic [PIXEL_W-1:0] din,
   output logic      [PIXEL_W-1:0] rd_row1,
   output logic      [PIXEL_W-1:0] rd_row0
);

   logic [PIXEL_W-1:0] line1_q [IMG_WIDTH];
   logic [PIXEL_W-1:0] line0_q [IMG_WIDTH];

   assign rd_row1 = line1_q[col];
   assign rd_row0 = line0_q[col];

   // Storage is never emitted before being refilled, so it carries no reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         line1_q[col] <= line0_q[col];
         line0_q[col] <= din;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cell_window_builder.sv
//------------------------------------------------------------------------------
// cell_window_builder
// Builds 3x3 cells from two lockstep raster pixel streams and presents them
// with opcode/user operand latched once per frame over a valid/ready bus.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cell_window_builder
   import cell_window_builder_pkg::*;
#(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64,
   parameter int PIXEL_W    = 8,
   parameter int OPCODE_W   = opCodeWidth,
   parameter int USER_W     = 8
) (
   input  wire logic                clk,
   input  wire logic                rst,
   input  wire logic                frame_start,
   input  wire logic [OPCODE_W-1:0] opcode_in,
   input  wire logic [USER_W-1:0]   user_in,
   input  wire logic                pix_valid,
   output logic                     pix_ready,
   input  wire logic [PIXEL_W-1:0]  pix_a,
   input  wire logic [PIXEL_W-1:0]  pix_b,
   cell_window_builder_if.master    cell_if,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int RW    = $clog2(IMG_HEIGHT);
   localparam int CW    = $clog2(IMG_WIDTH);
   localparam int DEPTH = 9 * PIXEL_W;

   cellWinState_t     state_q, state_d;
   logic [RW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic [DEPTH-1:0]  win_a_q, win_a_d, win_b_q, win_b_d;
   logic              cell_valid_q, cell_valid_d;
   logic [DEPTH-1:0]  cell_a_q, cell_a_d, cell_b_q, cell_b_d;
   logic [RW-1:0]     cell_row_q, cell_row_d;
   logic [CW-1:0]     cell_col_q, cell_col_d;
   logic [OPCODE_W-1:0] opcode_q, opcode_d;
   logic [USER_W-1:0] user_q, user_d;
   logic              frame_done_q, frame_done_d;

   logic [PIXEL_W-1:0] lb_a1, lb_a0, lb_b1, lb_b0;
   logic               accept, emit, last_col, last_row;

   assign pix_ready = (state_q == ACTIVE) && (!cell_valid_q || cell_if.cell_ready);
   assign accept    = pix_valid && pix_ready;
   assign last_col  = (col_q == CW'(IMG_WIDTH - 1));
   assign last_row  = (row_q == RW'(IMG_HEIGHT - 1));
   assign emit      = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

   cell_window_builder_line_buffer #(
      .IMG_WIDTH (IMG_WIDTH),
      .PIXEL_W   (PIXEL_W),
      .CW        (CW)
   ) u_lb_a (
      .clk     (clk),
      .wr_en   (accept),
      .col     (col_q),
      .din     (pix_a),
      .rd_row1 (lb_a1),
      .rd_row0 (lb_a0)
   );

   cell_window_builder_line_buffer #(
      .IMG_WIDTH (IMG_WIDTH),
      .PIXEL_W   (PIXEL_W),
      .CW        (CW)
   ) u_lb_b (
      .clk     (clk),
      .wr_en   (accept),
      .col     (col_q),
      .din     (pix_b),
      .rd_row1 (lb_b1),
      .rd_row0 (lb_b0)
   );

   // Window shifts left on each accepted pixel; new right column comes from the line buffers
   always_comb begin
      win_a_d = win_a_q;
      win_b_d = win_b_q;
      if (accept) begin
         for (int wr = 0; wr < 3; wr++) begin
            win_a_d[PIXEL_W*(3*wr)   +: PIXEL_W] = win_a_q[PIXEL_W*(3*wr+1) +: PIXEL_W];
            win_a_d[PIXEL_W*(3*wr+1) +: PIXEL_W] = win_a_q[PIXEL_W*(3*wr+2) +: PIXEL_W];
            win_b_d[PIXEL_W*(3*wr)   +: PIXEL_W] = win_b_q[PIXEL_W*(3*wr+1) +: PIXEL_W];
            win_b_d[PIXEL_W*(3*wr+1) +: PIXEL_W] = win_b_q[PIXEL_W*(3*wr+2) +: PIXEL_W];
         end
         win_a_d[PIXEL_W*2    +: PIXEL_W] = lb_a1;
         win_a_d[PIXEL_W*5    +: PIXEL_W] = lb_a0;
         win_a_d[PIXEL_W*K_BR +: PIXEL_W] = pix_a;
         win_b_d[PIXEL_W*2    +: PIXEL_W] = lb_b1;
         win_b_d[PIXEL_W*5    +: PIXEL_W] = lb_b0;
         win_b_d[PIXEL_W*K_BR +: PIXEL_W] = pix_b;
      end
   end

   // Next-state for the frame FSM, raster counters and the cell output register
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      opcode_d     = opcode_q;
      user_d       = user_q;
      cell_valid_d = cell_valid_q;
      cell_a_d     = cell_a_q;
      cell_b_d     = cell_b_q;
      cell_row_d   = cell_row_q;
      cell_col_d   = cell_col_q;
      frame_done_d = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               opcode_d = opcode_in;
               user_d   = user_in;
               row_d    = '0;
               col_d    = '0;
               state_d  = ACTIVE;
            end
         end
         ACTIVE: begin
            if (accept) begin
               if (last_col) begin
                  col_d = '0;
                  row_d = last_row ? '0 : row_q + RW'(1);
                  if (last_row) begin
                     state_d = DRAIN;
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         DRAIN: begin
            if (cell_valid_q && cell_if.cell_ready) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (cell_valid_q && cell_if.cell_ready) begin
         cell_valid_d = 1'b0;
      end
      if (emit) begin
         cell_valid_d = 1'b1;
         cell_a_d     = win_a_d;
         cell_b_d     = win_b_d;
         cell_row_d   = row_q - RW'(1);
         cell_col_d   = col_q - CW'(1);
      end
   end

   // Control and output registers, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         row_q        <= '0;
         col_q        <= '0;
         opcode_q     <= '0;
         user_q       <= '0;
         cell_valid_q <= 1'b0;
         cell_a_q     <= '0;
         cell_b_q     <= '0;
         cell_row_q   <= '0;
         cell_col_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         opcode_q     <= opcode_d;
         user_q       <= user_d;
         cell_valid_q <= cell_valid_d;
         cell_a_q     <= cell_a_d;
         cell_b_q     <= cell_b_d;
         cell_row_q   <= cell_row_d;
         cell_col_q   <= cell_col_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Window contents are always refilled before use, so they are not reset
   always_ff @(posedge clk) begin
      win_a_q <= win_a_d;
      win_b_q <= win_b_d;
   end

   assign cell_if.cell_valid = cell_valid_q;
   assign cell_if.cellA      = cell_a_q;
   assign cell_if.cellB      = cell_b_q;
   assign cell_if.cell_row   = cell_row_q;
   assign cell_if.cell_col   = cell_col_q;
   assign cell_if.opcode     = opcode_q;
   assign cell_if.userInputA = user_q;
   assign busy               = (state_q != IDLE);
   assign frame_done         = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_cell_window_builder.sv
//------------------------------------------------------------------------------
// tb_cell_window_builder
// Scoreboard bench for cell_window_builder: a 4x4 instance and a 3x3 instance.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cell_window_builder;
   import cell_window_builder_pkg::*;

   typedef struct {
      logic [71:0] a;
      logic [71:0] b;
      logic [1:0]  row;
      logic [1:0]  col;
      logic [3:0]  op;
      logic [7:0]  us;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // 4x4 instance
   logic       fs4 = 0, pv4 = 0, pr4, busy4, fd4;
   logic [3:0] op4 = 0;
   logic [7:0] us4 = 0, pa4 = 0, pb4 = 0;
   cell_window_builder_if #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) if4 ();
   cell_window_builder #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut4 (
      .clk(clk), .rst(rst), .frame_start(fs4), .opcode_in(op4), .user_in(us4),
      .pix_valid(pv4), .pix_ready(pr4), .pix_a(pa4), .pix_b(pb4),
      .cell_if(if4), .busy(busy4), .frame_done(fd4));

   // 3x3 instance
   logic       fs3 = 0, pv3 = 0, pr3, busy3, fd3;
   logic [3:0] op3 = 0;
   logic [7:0] us3 = 0, pa3 = 0, pb3 = 0;
   cell_window_builder_if #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) if3 ();
   cell_window_builder #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) u_dut3 (
      .clk(clk), .rst(rst), .frame_start(fs3), .opcode_in(op3), .user_in(us3),
      .pix_valid(pv3), .pix_ready(pr3), .pix_a(pa3), .pix_b(pb3),
      .cell_if(if3), .busy(busy3), .frame_done(fd3));

   logic cr4 = 1'b1;
   logic cr3 = 1'b1;
   assign if4.cell_ready = cr4;
   assign if3.cell_ready = cr3;

   exp_t q4[$];
   exp_t q3[$];
   logic [3:0] cur_op;
   logic [7:0] cur_us;
   int   cells4 = 0, fdcnt4 = 0, last_hs4 = 0;
   int   cells3 = 0, fdcnt3 = 0, last_hs3 = 0;
   logic stop_rand = 1'b0;

   task automatic chk(input string name, input logic [71:0] got, input logic [71:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
      end
   endtask

   task automatic cmp_cell(input string tag, input exp_t e, input logic [71:0] a,
                           input logic [71:0] b, input logic [1:0] r, input logic [1:0] c,
                           input logic [3:0] op, input logic [7:0] us);
      chk({tag, "_cellA"}, a, e.a);
      chk({tag, "_cellB"}, b, e.b);
      chk({tag, "_row"}, 72'(r), 72'(e.row));
      chk({tag, "_col"}, 72'(c), 72'(e.col));
      chk({tag, "_opcode"}, 72'(op), 72'(e.op));
      chk({tag, "_user"}, 72'(us), 72'(e.us));
      chk({tag, "_latency"}, 72'(cyc), 72'(e.acc + 1));
   endtask

   // Expected cell for 4x4 frame pixel (r,c): A=4r+c, B=255-A
   function automatic exp_t mk4(int r, int c, logic [3:0] op, logic [7:0] us, int acc);
      exp_t e;
      for (int wr = 0; wr < 3; wr++)
         for (int wc = 0; wc < 3; wc++) begin
            int v;
            v = 4 * (r - 2 + wr) + (c - 2 + wc);
            e.a[8*(3*wr+wc) +: 8] = 8'(v);
            e.b[8*(3*wr+wc) +: 8] = 8'(255 - v);
         end
      e.row = 2'(r - 1);
      e.col = 2'(c - 1);
      e.op  = op;
      e.us  = us;
      e.acc = acc;
      return e;
   endfunction

   // Monitor for the 4x4 instance: pop and compare on each newly presented cell
   logic        stall4 = 0;
   logic [71:0] hold_a;
   logic [1:0]  hold_row, hold_col;
   always @(negedge clk) begin
      #2;
      if (rst) begin
         stall4 = 0;
      end else begin
         if (stall4) begin
            chk("hold_cellA", if4.cellA, hold_a);
            chk("hold_row", 72'(if4.cell_row), 72'(hold_row));
            chk("hold_col", 72'(if4.cell_col), 72'(hold_col));
         end
         if (if4.cell_valid) begin
            if (!stall4) begin
               if (q4.size() == 0) begin
                  chk("unexpected_cell4", 72'(1), 72'(0));
               end else begin
                  cmp_cell("c4", q4[0], if4.cellA, if4.cellB, if4.cell_row,
                           if4.cell_col, if4.opcode, if4.userInputA);
                  void'(q4.pop_front());
               end
            end
            if (if4.cell_ready) begin
               cells4++;
               last_hs4 = cyc;
            end else begin
               chk("pix_ready_during_stall", 72'(pr4), 72'(0));
               hold_a   = if4.cellA;
               hold_row = if4.cell_row;
               hold_col = if4.cell_col;
            end
         end
         stall4 = if4.cell_valid && !if4.cell_ready;
         if (fd4) begin
            fdcnt4++;
            chk("frame_done_timing4", 72'(cyc), 72'(last_hs4 + 2));
         end
      end
   end

   // Monitor for the 3x3 instance (consumer always ready)
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (if3.cell_valid) begin
            if (q3.size() == 0) begin
               chk("unexpected_cell3", 72'(1), 72'(0));
            end else begin
               cmp_cell("c3", q3[0], if3.cellA, if3.cellB, if3.cell_row,
                        if3.cell_col, if3.opcode, if3.userInputA);
               void'(q3.pop_front());
            end
            cells3++;
            last_hs3 = cyc;
         end
         if (fd3) begin
            fdcnt3++;
            chk("frame_done_timing3", 72'(cyc), 72'(last_hs3 + 2));
         end
      end
   end

   // Drive one 4x4 frame (or its first n_pix pixels); mid_idx>=0 pulses a stray frame_start
   task automatic drive_frame4(input logic [3:0] op, input logic [7:0] us, input int gap,
                               input int mid_idx, input int n_pix);
      @(negedge clk);
      fs4 = 1; op4 = op; us4 = us;
      cur_op = op; cur_us = us;
      @(negedge clk);
      fs4 = 0;
      for (int idx = 0; idx < n_pix; idx++) begin
         int   r, c, acc;
         logic rdy, ok;
         r = idx / 4;
         c = idx % 4;
         ok = 0;
         acc = 0;
         if (gap > 0) repeat ($urandom_range(0, gap)) begin
            @(negedge clk);
            pv4 = 0;
            fs4 = 0;
         end
         for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            pv4 = 1;
            pa4 = 8'(4 * r + c);
            pb4 = 8'(255 - (4 * r + c));
            fs4 = (idx == mid_idx);
            if (idx == mid_idx) begin
               op4 = 4'd7;
               us4 = 8'h11;
            end
            #1;
            rdy = pr4;
            acc = cyc;
            @(posedge clk);
            if (rdy) ok = 1;
         end
         if (!ok) chk("pixel_accept_timeout", 72'(0), 72'(1));
         else if (r >= 2 && c >= 2) q4.push_back(mk4(r, c, cur_op, cur_us, acc));
      end
      @(negedge clk);
      pv4 = 0;
      fs4 = 0;
   endtask

   // Wait (bounded) for the 4x4 frame to finish and check cell count
   task automatic finish_frame4(input int cells_before);
      logic seen;
      seen = 0;
      for (int t = 0; t < 200 && !seen; t++) begin
         @(negedge clk);
         #3;
         if (fd4) seen = 1;
      end
      chk("frame_done_seen4", 72'(seen), 72'(1));
      chk("queue_empty4", 72'(q4.size()), 72'(0));
      chk("cell_count4", 72'(cells4 - cells_before), 72'(4));
      @(negedge clk);
      #3;
      chk("busy_idle4", 72'(busy4), 72'(0));
      chk("frame_done_pulse4", 72'(fd4), 72'(0));
   endtask

   task automatic rand_ready();
      while (!stop_rand) begin
         @(negedge clk);
         cr4 = 1'($urandom_range(0, 1));
      end
      cr4 = 1'b1;
   endtask

   task automatic bp_proc();
      logic seen;
      seen = 0;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(negedge clk);
         if (if4.cell_valid) seen = 1;
      end
      chk("bp_first_cell_seen", 72'(seen), 72'(1));
      cr4 = 1'b0;
      repeat (5) @(negedge clk);
      cr4 = 1'b1;
   endtask

   initial begin
      int c0, fd0;
      logic seen3;
      repeat (3) @(negedge clk);
      #3;
      // reset state of both instances
      chk("rst_cell_valid4", 72'(if4.cell_valid), 72'(0));
      chk("rst_pix_ready4", 72'(pr4), 72'(0));
      chk("rst_busy4", 72'(busy4), 72'(0));
      chk("rst_frame_done4", 72'(fd4), 72'(0));
      chk("rst_cellA4", if4.cellA, 72'(0));
      chk("rst_cellB4", if4.cellB, 72'(0));
      chk("rst_opcode4", 72'(if4.opcode), 72'(0));
      chk("rst_user4", 72'(if4.userInputA), 72'(0));
      chk("rst_rowcol4", 72'({if4.cell_row, if4.cell_col}), 72'(0));
      chk("rst_cell_valid3", 72'(if3.cell_valid), 72'(0));
      chk("rst_busy3", 72'(busy3), 72'(0));
      @(negedge clk);
      rst = 0;

      // basic frame, consumer always ready
      c0 = cells4;
      drive_frame4(4'd1, 8'h20, 0, -1, 16);
      finish_frame4(c0);

      // backpressure after first cell
      c0 = cells4;
      fork
         drive_frame4(4'd2, 8'h33, 0, -1, 16);
         bp_proc();
      join
      finish_frame4(c0);

      // frame latch: stray frame_start with new opcode/user mid-frame
      c0 = cells4;
      drive_frame4(4'd3, 8'h5A, 0, 5, 16);
      finish_frame4(c0);

      // reset after 7 accepted pixels
      fd0 = fdcnt4;
      drive_frame4(4'd4, 8'h44, 0, -1, 7);
      rst = 1;
      @(negedge clk);
      rst = 0;
      #3;
      chk("abort_cell_valid", 72'(if4.cell_valid), 72'(0));
      chk("abort_busy", 72'(busy4), 72'(0));
      chk("abort_opcode_cleared", 72'(if4.opcode), 72'(0));
      repeat (8) @(negedge clk);
      chk("abort_no_frame_done", 72'(fdcnt4), 72'(fd0));
      chk("abort_queue_empty", 72'(q4.size()), 72'(0));

      // fresh frame after abort
      c0 = cells4;
      drive_frame4(4'd6, 8'h66, 0, -1, 16);
      finish_frame4(c0);

      // random input gaps and random consumer ready
      c0 = cells4;
      stop_rand = 0;
      fork
         begin
            drive_frame4(4'd9, 8'h99, 3, -1, 16);
            finish_frame4(c0);
            stop_rand = 1;
         end
         rand_ready();
      join

      // 3x3 frame, pixels 1..9: exactly one cell
      @(negedge clk);
      fs3 = 1; op3 = 4'd5; us3 = 8'h22;
      @(negedge clk);
      fs3 = 0;
      for (int v = 1; v <= 9; v++) begin
         logic ok, rdy;
         int   acc;
         ok = 0;
         acc = 0;
         for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            pv3 = 1; pa3 = 8'(v); pb3 = 8'(100 + v);
            #1;
            rdy = pr3;
            acc = cyc;
            @(posedge clk);
            if (rdy) ok = 1;
         end
         if (!ok) chk("pixel_accept_timeout3", 72'(0), 72'(1));
         else if (v == 9) begin
            exp_t e;
            for (int k = 0; k < 9; k++) begin
               e.a[8*k +: 8] = 8'(k + 1);
               e.b[8*k +: 8] = 8'(101 + k);
            end
            e.row = 2'd1; e.col = 2'd1; e.op = 4'd5; e.us = 8'h22; e.acc = acc;
            q3.push_back(e);
         end
      end
      @(negedge clk);
      pv3 = 0;
      seen3 = 0;
      for (int t = 0; t < 50 && !seen3; t++) begin
         @(negedge clk);
         #3;
         if (fd3) seen3 = 1;
      end
      chk("frame_done_seen3", 72'(seen3), 72'(1));
      chk("cell_count3", 72'(cells3), 72'(1));
      chk("queue_empty3", 72'(q3.size()), 72'(0));
      @(negedge clk);
      #3;
      chk("busy_idle3", 72'(busy3), 72'(0));
      chk("frame_done_count3", 72'(fdcnt3), 72'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/cell_window_builder.md
Name: cell_window_builder

Overview:
Upstream stage of the cell processor. Takes two lockstep raster pixel streams (image A and image B) and builds 3x3 pixel neighbourhoods, called cells, using per-image line buffers. It drives cellA, cellB, userInputA and opcode through the imagePorts side of cellProcessor_int, with a valid/ready handshake. Opcode and user input are latched once per frame, so every cell in a frame carries the same operation.

Parameters:
IMG_WIDTH, 64, pixels per row (min 3)
IMG_HEIGHT, 64, rows per frame (min 3)
PIXEL_W, 8, bits per pixel (width of CellProcessingPkg::pixel_t)
OPCODE_W, opCodeWidth, opcode width
USER_W, 8, width of CellProcessingPkg::userInput_t

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
frame_start  in  1  pulse; starts a frame; latches opcode_in and user_in
opcode_in  in  OPCODE_W  operation for the frame
user_in  in  USER_W  user operand for the frame
pix_valid  in  1  input pixel pair valid
pix_ready  out  1  input pixel pair accepted when pix_valid && pix_ready
pix_a  in  PIXEL_W  image A pixel
pix_b  in  PIXEL_W  image B pixel
cell_valid  out  1  cell outputs valid
cell_ready  in  1  consumer accepts the cell
cellA  out  9*PIXEL_W  image A window (cellDepth)
cellB  out  9*PIXEL_W  image B window
userInputA  out  USER_W  latched user operand
opcode  out  OPCODE_W  latched opcode
cell_row  out  $clog2(IMG_HEIGHT)  centre row of the cell
cell_col  out  $clog2(IMG_WIDTH)  centre column of the cell
busy  out  1  high when not IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset:
  - State goes to IDLE; row and column counters clear to 0.
  - All outputs go to 0: cell_valid, pix_ready, busy, frame_done, cellA, cellB, opcode, userInputA, cell_row, cell_col.
  - Line buffer and window contents are not reset; they are never emitted before being refilled.
- States:
  - IDLE: pix_ready=0. frame_start latches opcode_in and user_in into opcode and userInputA, clears the counters, and moves to ACTIVE.
  - ACTIVE: accepts pixels.
  - DRAIN: entered after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted. Moves to DONE on the cycle the final cell handshakes (cell_valid && cell_ready).
  - DONE: frame_done=1 for one cycle, then IDLE.
- frame_start is ignored outside IDLE.
- pix_ready = (state==ACTIVE) && (!cell_valid || cell_ready). Pixels are ignored when pix_ready=0.
- On each accepted pixel at (r,c):
  - Shift the 3x3 window left by one column for both images. The new right column is {linebuf1[c], linebuf0[c], pixel}, ordered oldest row to newest.
  - Write linebuf1[c] <= linebuf0[c] and linebuf0[c] <= pixel.
  - Increment c; at IMG_WIDTH-1, wrap c to 0 and increment r.
- Cell emission:
  - An accepted pixel with r>=2 && c>=2 loads the output register on the next edge. Latency is 1 cycle.
  - Outputs: cell_valid=1, cell_row=r-1, cell_col=c-1.
  - Packing: cellA[PIXEL_W*k +: PIXEL_W] = window pixel k, where k = 3*wrow + wcol. k=0 is top-left (r-2,c-2); k=8 is the current pixel. cellB is packed identically.
- Pixels with r<2 or c<2 only fill the buffers; no cell is emitted. A frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) cells in raster order.
- Output holding:
  - While cell_valid && !cell_ready, all cell outputs hold stable.
  - cell_valid clears on a handshake unless a new cell loads in the same cycle.
- opcode and userInputA stay constant from frame_start until the next accepted frame_start.
- Reset mid-frame aborts: no frame_done, partial cells are discarded, and state returns to IDLE.
- busy = (state != IDLE).

Decomposition:
- CellProcessingPkg gains:
  - cellDepth = 9*PIXEL_W
  - cellWinState_t enum {IDLE, ACTIVE, DRAIN, DONE}
  - cell index helper constants K_TL=0, K_CTR=4, K_BR=8
- pixel_t, userInput_t and opCodeWidth are reused from CellProcessingPkg.
- One sub-module, cell_line_buffer, instantiated once per image:
  - 2 rows x IMG_WIDTH x PIXEL_W register array
  - combinational read at the column address
  - write enable on pixel accept

Test Plan:
- 4x4 frame, pix_a = 4r+c, pix_b = 255-(4r+c), cell_ready=1 -> 4 cells. First cell: cellA k0..k8 = {0,1,2,4,5,6,8,9,10}, cell_row=1, cell_col=1, cell_valid the cycle after pixel 10 is accepted. frame_done pulses 2 cycles after the last cell handshake.
- Backpressure: same frame, cell_ready=0 for 5 cycles after the first cell -> pix_ready=0 and cellA/cell_row stable throughout. On release, all 4 cells arrive in order, none lost or duplicated.
- Frame latch: frame_start with opcode_in=3, user_in=0x5A; change to opcode_in=7, user_in=0x11 mid-frame and pulse frame_start -> every cell shows opcode=3, userInputA=0x5A; the second frame_start is ignored.
- Reset after 7 accepted pixels -> the next cycle shows cell_valid=0, busy=0, no frame_done. A fresh 4x4 frame then produces a correct first cell.
- Default 64x64 frame, random pix_valid gaps and random cell_ready -> exactly 3844 cells, matching a reference model. No cell has cell_col=0 or 63, or cell_row=0 or 63.
- 3x3 frame (IMG_WIDTH=IMG_HEIGHT=3), pixels 1..9 -> exactly one cell with cellA = {1..9}, cell_row=cell_col=1, then frame_done and IDLE.
